// File: rtl/riscv_alu_sequencer_if.sv
// Execute-stage bundle: CPU control handshake plus the shared ALU port.
// The sequencer is the slave of the control FSM and the initiator on the ALU.
interface riscv_alu_sequencer_if;
    logic        START;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNCT3;
    logic        FUNCT7_5;
    logic [31:0] PC;
    logic [31:0] RS1;
    logic [31:0] RS2;
    logic [31:0] IMM;
    logic [31:0] ALU_A;
    logic [31:0] ALU_B;
    logic [3:0]  ALU_OP;
    logic [31:0] ALU_C;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;
    logic [31:0] NEXT_PC;
    logic        TAKEN;
    logic        ILLEGAL;

    modport slave (
        input  START, OPCODE, FUNCT3, FUNCT7_5,
        input  PC, RS1, RS2, IMM, ALU_C,
        output ALU_A, ALU_B, ALU_OP,
        output BUSY, DONE, RESULT, NEXT_PC,
        output TAKEN, ILLEGAL
    );

    modport master (
        output START, OPCODE, FUNCT3, FUNCT7_5,
        output PC, RS1, RS2, IMM, ALU_C,
        input  ALU_A, ALU_B, ALU_OP,
        input  BUSY, DONE, RESULT, NEXT_PC,
        input  TAKEN, ILLEGAL
    );
endinterface

// File: rtl/riscv_alu_sequencer.sv
// RV32I execute sequencer: EX1 computes the result/branch test,
// EX2 reuses the same ALU for the next PC, FIN reports completion.
module riscv_alu_sequencer (
    input  logic CLK,
    input  logic RSTn,
    riscv_alu_sequencer_if.slave bus
);
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b1000;
    localparam logic [3:0] OP_PASSB = 4'b1001;

    typedef enum logic [1:0] {
        IDLE,
        EX1,
        EX2,
        FIN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;

    logic [31:0] result;
    logic [31:0] next_pc;
    logic        taken;
    logic        illegal;

    logic        accept;
    logic        legal_in;
    logic        is_br;
    logic        is_jmp;
    logic        br_take;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;

    assign accept = (state == IDLE) && bus.START;
    assign is_br  = (opc == OPC_BR);
    assign is_jmp = (opc == OPC_JAL) || (opc == OPC_JALR);

    // Only the branch group has reserved funct3 encodings worth rejecting.
    always_comb begin
        legal_in = 1'b0;
        case (bus.OPCODE)
            OPC_R, OPC_IMM, OPC_LUI, OPC_AUIPC,
            OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR:
                legal_in = 1'b1;
            OPC_BR:
                legal_in = (bus.FUNCT3[2:1] != 2'b01);
            default:
                legal_in = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.START) state_nx = legal_in ? EX1 : FIN;
            EX1:  state_nx = EX2;
            EX2:  state_nx = FIN;
            FIN:  state_nx = IDLE;
        endcase
    end

    // Equality tests use SUB (zero check), ordering tests use SLT/SLTU bit 0.
    always_comb begin
        if (f3[2]) begin
            br_take = bus.ALU_C[0] ^ f3[0];
        end else begin
            br_take = (bus.ALU_C == 32'd0) ^ f3[0];
        end
    end

    always_comb begin
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        alu_op = OP_ADD;
        unique case (state)
            EX1: begin
                case (opc)
                    OPC_R: begin
                        alu_a  = rs1;
                        alu_b  = rs2;
                        alu_op = {f7, f3};
                    end
                    OPC_IMM: begin
                        alu_a  = rs1;
                        alu_b  = imm;
                        alu_op = (f3 == 3'b101) ? {f7, f3}
                                                : {1'b0, f3};
                    end
                    OPC_LUI: begin
                        alu_b  = imm;
                        alu_op = OP_PASSB;
                    end
                    OPC_AUIPC: begin
                        alu_a = pc;
                        alu_b = imm;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_a = rs1;
                        alu_b = imm;
                    end
                    OPC_JAL, OPC_JALR: begin
                        alu_a = pc;
                        alu_b = 32'd4;
                    end
                    OPC_BR: begin
                        alu_a  = rs1;
                        alu_b  = rs2;
                        alu_op = f3[2] ? {3'b001, f3[1]} : OP_SUB;
                    end
                    default: begin
                        alu_a = 32'd0;
                    end
                endcase
            end
            EX2: begin
                alu_a = pc;
                alu_b = 32'd4;
                if (opc == OPC_JAL) begin
                    alu_b = imm;
                end else if (opc == OPC_JALR) begin
                    alu_a = rs1;
                    alu_b = imm;
                end else if (is_br && taken) begin
                    alu_b = imm;
                end
            end
            IDLE, FIN: begin
                alu_a = 32'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state   <= IDLE;
            opc     <= 7'd0;
            f3      <= 3'd0;
            f7      <= 1'b0;
            pc      <= 32'd0;
            rs1     <= 32'd0;
            rs2     <= 32'd0;
            imm     <= 32'd0;
            result  <= 32'd0;
            next_pc <= 32'd0;
            taken   <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                opc     <= bus.OPCODE;
                f3      <= bus.FUNCT3;
                f7      <= bus.FUNCT7_5;
                pc      <= bus.PC;
                rs1     <= bus.RS1;
                rs2     <= bus.RS2;
                imm     <= bus.IMM;
                result  <= 32'd0;
                next_pc <= 32'd0;
                taken   <= 1'b0;
                illegal <= !legal_in;
            end
            if (state == EX1) begin
                result <= is_br ? 32'd0 : bus.ALU_C;
                taken  <= is_br ? br_take : 1'b0;
            end
            if (state == EX2) begin
                if (opc == OPC_JALR) begin
                    next_pc <= {bus.ALU_C[31:1], 1'b0};
                end else begin
                    next_pc <= bus.ALU_C;
                end
                if (is_jmp) begin
                    taken <= 1'b1;
                end
            end
        end
    end

    assign bus.ALU_A   = alu_a;
    assign bus.ALU_B   = alu_b;
    assign bus.ALU_OP  = alu_op;
    assign bus.BUSY    = (state != IDLE);
    assign bus.DONE    = (state == FIN);
    assign bus.RESULT  = result;
    assign bus.NEXT_PC = next_pc;
    assign bus.TAKEN   = taken;
    assign bus.ILLEGAL = illegal;
endmodule

// File: doc/riscv_alu_sequencer.md
# riscv_alu_sequencer

Multi-cycle execute-stage sequencer that drives the shared 32-bit ALU from the initiator side. It decodes RV32I instruction fields into ALU operand selections and 4-bit OP codes, then time-multiplexes the single ALU over two execute cycles. It returns the writeback result, next PC and branch decision to the multi-cycle CPU control FSM over a start/done handshake.

## Interface
- No parameters. Data width is fixed at 32 bits, and the ALU OP field is fixed at 4 bits.
- CLK  in  1  single clock; all state updates on the rising edge.
- RSTn  in  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- START  in  1  request pulse; accepted only in IDLE.
- OPCODE  in  7  instruction[6:0], sampled with START.
- FUNCT3  in  3  instruction[14:12], sampled with START.
- FUNCT7_5  in  1  instruction[30], sampled with START.
- PC, RS1, RS2, IMM  in  32 each  current PC, register operands and sign-extended immediate; sampled with START.
- ALU_A, ALU_B  out  32  ALU operands.
- ALU_OP  out  4  ALU operation code.
- ALU_C  in  32  ALU combinational result.
- BUSY  out  1  high from the cycle after acceptance through the DONE cycle.
- DONE  out  1  one-cycle completion pulse.
- RESULT  out  32  writeback value, or memory address for load/store.
- NEXT_PC  out  32  next PC.
- TAKEN  out  1  branch or jump redirect.
- ILLEGAL  out  1  unsupported opcode or funct3.

## Operation
- ALU OP codes:
  - ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111.
  - SUB 1000, SRA 1101, PASSB 1001.
- On acceptance (START=1 in IDLE), all inputs are latched into internal registers. Later input changes have no effect.
- States and transitions:
  - IDLE goes to EX1 on START.
  - IDLE goes to FIN on START with an illegal opcode.
  - EX1 goes to EX2.
  - EX2 goes to FIN.
  - FIN goes to IDLE.
- ALU_A, ALU_B and ALU_OP are combinational from the state and the latched fields. In IDLE and FIN they are 0, 0 and 0000.
- EX1 (primary operation) drives the ALU as follows, and the registered result is captured from ALU_C at the end of EX1:
  - OP-R (0110011): A=RS1, B=RS2, OP={FUNCT7_5,FUNCT3}.
  - OP-IMM (0010011): A=RS1, B=IMM. OP={FUNCT7_5,FUNCT3} when FUNCT3=101; otherwise OP={0,FUNCT3}.
  - LUI (0110111): B=IMM, OP=PASSB.
  - AUIPC (0010111): A=PC, B=IMM, OP=ADD.
  - LOAD (0000011) and STORE (0100011): A=RS1, B=IMM, OP=ADD.
  - JAL (1101111) and JALR (1100111): A=PC, B=4, OP=ADD (link value).
  - BRANCH (1100011): A=RS1, B=RS2. FUNCT3 00x uses SUB, 10x uses SLT, 11x uses SLTU.
- Branch decision, registered at the end of EX1:
  - FUNCT3 00x: TAKEN = (ALU_C==0) XOR FUNCT3[0].
  - FUNCT3 1xx: TAKEN = ALU_C[0] XOR FUNCT3[0].
  - RESULT is 0 for branches.
  - BRANCH with FUNCT3 010 or 011 is illegal.
- EX2 (next PC), always OP=ADD; NEXT_PC is captured from ALU_C:
  - JAL: A=PC, B=IMM. TAKEN=1.
  - JALR: A=RS1, B=IMM. NEXT_PC = ALU_C with bit 0 cleared. TAKEN=1.
  - BRANCH: A=PC, B = IMM if taken, else 4.
  - All other opcodes: A=PC, B=4. TAKEN=0.
- Illegal handling:
  - An unlisted opcode skips EX1 and EX2.
  - An illegal branch funct3 is detected at acceptance and also skips EX1 and EX2.
  - In both cases FIN presents ILLEGAL=1, RESULT=0, NEXT_PC=0, TAKEN=0.
- Wrap-around: all adds are modulo 2^32. PC=FFFFFFFC with +4 gives NEXT_PC=00000000.

## Timing
- Reset (RSTn=0 at a clock edge) forces:
  - state = IDLE;
  - BUSY, DONE, TAKEN, ILLEGAL = 0;
  - RESULT, NEXT_PC = 0;
  - all latched fields cleared.
- Reset wins over START in the same cycle. Reset mid-operation abandons the instruction, and no DONE is produced.
- Latency, with acceptance edge at cycle 0:
  - legal instruction: EX1 in cycle 1, EX2 in cycle 2, DONE=1 in cycle 3;
  - illegal instruction: DONE=1 in cycle 1.
- DONE is high for exactly one cycle.
- RESULT, NEXT_PC, TAKEN and ILLEGAL are valid in the DONE cycle. They hold until the next acceptance and are cleared at that acceptance.
- START is ignored while BUSY=1, including the FIN cycle. Maximum throughput is one instruction per 4 cycles; the earliest restart is the cycle after DONE.
- No combinational path exists from START to any output.

## Test plan
- ADD R-type, RS1=5, RS2=7, PC=100: ALU_OP=0000 in cycle 1, DONE in cycle 3, RESULT=12, NEXT_PC=104, TAKEN=0.
- SRAI, FUNCT3=101, FUNCT7_5=1, RS1=80000000, IMM=4: ALU_OP=1101, RESULT=F8000000.
- BLT, RS1=FFFFFFFF, RS2=1, IMM=-8, PC=200:
  - first check: TAKEN=1, NEXT_PC=1F8;
  - BLTU with the same operands: TAKEN=0, NEXT_PC=204.
- JALR, PC=40, RS1=1003, IMM=2: RESULT=44, NEXT_PC=1004, TAKEN=1.
- Illegal cases:
  - opcode 1111111: DONE one cycle after acceptance, ILLEGAL=1, other outputs 0;
  - BRANCH with FUNCT3=010: same response.
- Robustness:
  - RSTn=0 during EX2: no DONE, all outputs 0 next cycle;
  - START held high during BUSY: exactly one DONE per accepted instruction.
